// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath enable.
module multicycle_ctrl #(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t state, state_nxt;
    logic   mem_ok;
    logic   op_legal;

    // With wait states disabled the memory is assumed to always answer in one cycle
    assign mem_ok    = mem_ready | ~MEM_WAIT_EN;
    assign state_out = state;

    always_comb begin
        unique case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         illegal_op <= 1'b0;
        else if (state == DECODE && !op_legal) illegal_op <= 1'b1;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = EXEC;
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_J:         state_nxt = JUMP;
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_nxt = mem_ok ? MEMWB : MEMRD;
            MEMWR:  state_nxt = mem_ok ? FETCH : MEMWR;
            EXEC:   state_nxt = ALUWB;
            ADDIEX: state_nxt = ADDIWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
            end
            DECODE:  alu_src_b = 2'd3;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            ADDIWB:  reg_write = 1'b1;
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-word checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, rst_nw_n;
    logic [5:0] opcode, opcode_nw;
    logic       mem_ready;
    logic       mem_ready_nw;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_out;

    logic       pc_write_w, pc_write_cond_w, iord_w, mem_read_w, mem_write_w, ir_write_w;
    logic       mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, illegal_op_w;
    logic [1:0] alu_src_b_w, alu_op_w, pc_source_w;
    logic [3:0] state_out_w;

    logic [15:0] outs, outs_w;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_out(state_out)
    );

    multicycle_ctrl #(.MEM_WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_nw_n), .opcode(opcode_nw), .mem_ready(mem_ready_nw),
        .pc_write(pc_write_w), .pc_write_cond(pc_write_cond_w), .iord(iord_w),
        .mem_read(mem_read_w), .mem_write(mem_write_w), .ir_write(ir_write_w),
        .mem_to_reg(mem_to_reg_w), .reg_dst(reg_dst_w), .reg_write(reg_write_w),
        .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w),
        .pc_source(pc_source_w), .illegal_op(illegal_op_w), .state_out(state_out_w)
    );

    // Control word: pw,pwc,iord,mr,mw,irw,m2r,rdst,rw,asa,asb[1:0],aop[1:0],psrc[1:0]
    assign outs   = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign outs_w = {pc_write_w, pc_write_cond_w, iord_w, mem_read_w, mem_write_w, ir_write_w,
                     mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, alu_src_b_w, alu_op_w,
                     pc_source_w};

    localparam logic [15:0] W_FETCH  = 16'h9410;
    localparam logic [15:0] W_FWAIT  = 16'h1010;
    localparam logic [15:0] W_DECODE = 16'h0030;
    localparam logic [15:0] W_MEMADR = 16'h0060;
    localparam logic [15:0] W_MEMRD  = 16'h3000;
    localparam logic [15:0] W_MEMWB  = 16'h0280;
    localparam logic [15:0] W_MEMWR  = 16'h2800;
    localparam logic [15:0] W_EXEC   = 16'h0048;
    localparam logic [15:0] W_ALUWB  = 16'h0180;
    localparam logic [15:0] W_BRANCH = 16'h4045;
    localparam logic [15:0] W_ADDIWB = 16'h0080;
    localparam logic [15:0] W_JUMP   = 16'h8002;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then step to just after the next rising edge
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] w,
                       input logic ill);
        @(negedge clk);
        chk({tag, ".state"}, {12'd0, state_out}, {12'd0, st});
        chk({tag, ".ctrl"}, outs, w);
        chk({tag, ".ill"}, {15'd0, illegal_op}, {15'd0, ill});
        @(posedge clk); #1;
    endtask

    task automatic cyc_nw(input string tag, input logic [3:0] st, input logic [15:0] w);
        @(negedge clk);
        chk({tag, ".state"}, {12'd0, state_out_w}, {12'd0, st});
        chk({tag, ".ctrl"}, outs_w, w);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_nw_n = 1'b0;
        opcode = 6'h23; opcode_nw = 6'h23;
        mem_ready = 1'b1; mem_ready_nw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.state", {12'd0, state_out}, 16'd0);
        chk("rst.ctrl", outs, W_FETCH);
        chk("rst.ill", {15'd0, illegal_op}, 16'd0);
        rst_n = 1'b1;

        // lw, zero wait: 0,1,2,3,4,0
        cyc("lw0", 4'd0, W_FETCH, 1'b0);
        cyc("lw1", 4'd1, W_DECODE, 1'b0);
        cyc("lw2", 4'd2, W_MEMADR, 1'b0);
        cyc("lw3", 4'd3, W_MEMRD, 1'b0);
        cyc("lw4", 4'd4, W_MEMWB, 1'b0);

        // sw with 2 fetch waits and 3 MEMWR waits: 9 cycles
        opcode = 6'h2B; mem_ready = 1'b0;
        cyc("sw0", 4'd0, W_FWAIT, 1'b0);
        cyc("sw1", 4'd0, W_FWAIT, 1'b0);
        mem_ready = 1'b1;
        cyc("sw2", 4'd0, W_FETCH, 1'b0);
        cyc("sw3", 4'd1, W_DECODE, 1'b0);
        cyc("sw4", 4'd2, W_MEMADR, 1'b0);
        mem_ready = 1'b0;
        cyc("sw5", 4'd5, W_MEMWR, 1'b0);
        cyc("sw6", 4'd5, W_MEMWR, 1'b0);
        cyc("sw7", 4'd5, W_MEMWR, 1'b0);
        mem_ready = 1'b1;
        cyc("sw8", 4'd5, W_MEMWR, 1'b0);

        // R-type, beq, j
        opcode = 6'h00;
        cyc("r0", 4'd0, W_FETCH, 1'b0);
        cyc("r1", 4'd1, W_DECODE, 1'b0);
        cyc("r2", 4'd6, W_EXEC, 1'b0);
        cyc("r3", 4'd7, W_ALUWB, 1'b0);
        opcode = 6'h04;
        cyc("beq0", 4'd0, W_FETCH, 1'b0);
        cyc("beq1", 4'd1, W_DECODE, 1'b0);
        cyc("beq2", 4'd8, W_BRANCH, 1'b0);
        opcode = 6'h02;
        cyc("j0", 4'd0, W_FETCH, 1'b0);
        cyc("j1", 4'd1, W_DECODE, 1'b0);
        cyc("j2", 4'd11, W_JUMP, 1'b0);

        // illegal opcode, then addi with the sticky flag still up
        opcode = 6'h3F;
        cyc("ill0", 4'd0, W_FETCH, 1'b0);
        cyc("ill1", 4'd1, W_DECODE, 1'b0);
        opcode = 6'h08;
        cyc("addi0", 4'd0, W_FETCH, 1'b1);
        cyc("addi1", 4'd1, W_DECODE, 1'b1);
        cyc("addi2", 4'd9, W_MEMADR, 1'b1);
        cyc("addi3", 4'd10, W_ADDIWB, 1'b1);

        // reset asserted in the middle of a MEMWR wait
        opcode = 6'h2B;
        cyc("rsw0", 4'd0, W_FETCH, 1'b1);
        cyc("rsw1", 4'd1, W_DECODE, 1'b1);
        cyc("rsw2", 4'd2, W_MEMADR, 1'b1);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rsw3.state", {12'd0, state_out}, 16'd5);
        chk("rsw3.mw", {15'd0, mem_write}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async.mw", {15'd0, mem_write}, 16'd0);
        chk("async.state", {12'd0, state_out}, 16'd0);
        chk("async.ill", {15'd0, illegal_op}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc("post0", 4'd0, W_FETCH, 1'b0);
        cyc("post1", 4'd1, W_DECODE, 1'b0);

        // MEM_WAIT_EN=0 instance: mem_ready held low, lw still takes 5 cycles
        rst_nw_n = 1'b0;
        @(posedge clk); #1;
        rst_nw_n = 1'b1;
        cyc_nw("nw0", 4'd0, W_FETCH);
        cyc_nw("nw1", 4'd1, W_DECODE);
        cyc_nw("nw2", 4'd2, W_MEMADR);
        cyc_nw("nw3", 4'd3, W_MEMRD);
        cyc_nw("nw4", 4'd4, W_MEMWB);
        cyc_nw("nw5", 4'd0, W_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS-subset datapath.
- Directly downstream of the instruction register: consumes the registered opcode field.
- Sequences fetch/decode/execute/memory/writeback.
- Drives every datapath enable, including the instruction register's write enable (ir_write).

Parameters:
- MEM_WAIT_EN, 1, when 1 the FETCH, MEMRD and MEMWR states hold until mem_ready=1; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  opcode field from instruction register
- mem_ready  input  1  memory access complete this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load enable
- mem_to_reg  output  1  register write data: 0=ALUOut, 1=MDR
- reg_dst  output  1  dest register: 0=rt, 1=rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- alu_op  output  2  0=add, 1=sub, 2=funct-decoded
- pc_source  output  2  0=ALU result, 1=ALUOut, 2=jump target
- illegal_op  output  1  sticky flag, unsupported opcode decoded
- state_out  output  4  current state encoding (debug)

Behaviour:
- State register reset asynchronously on rst_n=0 to FETCH (0).
- illegal_op is cleared to 0 by reset.
- All other outputs are Moore, combinational from state (plus mem_ready in FETCH).
- Reset values follow from that: FETCH decode with mem_ready as sampled.
- State encodings and asserted outputs (unlisted outputs = 0):
  - FETCH=0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
    - ir_write = pc_write = (mem_ready | ~MEM_WAIT_EN).
    - Stays in FETCH until that condition is true, then goes to DECODE.
  - DECODE=1: alu_src_a=0, alu_src_b=3, alu_op=0. Branch by opcode:
    - 0x00 -> EXEC
    - 0x23, 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x08 -> ADDIEX
    - 0x02 -> JUMP
    - any other -> FETCH, and illegal_op set to 1
  - MEMADR=2: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEMRD (0x23) or MEMWR (0x2B).
  - MEMRD=3: mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB=4: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR=5: mem_write=1, iord=1. Holds until mem_ready, then goes to FETCH.
  - EXEC=6: alu_src_a=1, alu_src_b=0, alu_op=2. Goes to ALUWB.
  - ALUWB=7: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Goes to FETCH.
  - ADDIEX=9: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to ADDIWB.
  - ADDIWB=10: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - JUMP=11: pc_write=1, pc_source=2. Goes to FETCH.
- Encodings 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- opcode is sampled only in DECODE and MEMADR. The IR holds it stable because ir_write=0 outside FETCH.
- Latency in cycles, zero wait states:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each wait cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle.
- mem_read/mem_write stay asserted and iord stays constant for the whole wait.
- mem_write is never asserted in the same cycle as mem_read.
- ir_write and pc_write in FETCH are asserted for exactly one cycle per instruction: the cycle mem_ready=1.
- illegal_op stays 1 until rst_n=0. Execution continues with the next fetch.
- Reset mid-instruction (any state, any cycle phase): immediately FETCH.
  - reg_write/mem_write drop to 0 asynchronously with rst_n.

Test Plan:
- rst_n=0 while in MEMWR with mem_write=1 -> mem_write=0 same cycle, state_out=0, illegal_op=0 after release.
- opcode=0x23, mem_ready=1 always -> states 0,1,2,3,4,0.
  - ir_write=1 only in cycle 0; reg_write=1, mem_to_reg=1 only in cycle 4.
- opcode=0x2B, mem_ready low 2 cycles in FETCH and 3 cycles in MEMWR -> FETCH 3 cycles with ir_write=1 only on 3rd; MEMWR 4 cycles with mem_write=1 throughout, iord=1; total 9 cycles.
- opcode=0x00 then 0x04 then 0x02 -> state sequences 0,1,6,7 / 0,1,8 / 0,1,11.
  - alu_op=2 in EXEC; pc_write_cond=1, alu_op=1 in BRANCH; pc_write=1, pc_source=2 in JUMP.
- opcode=0x3F -> 0,1,0; illegal_op=1 from the cycle after DECODE; stays 1 through a following addi (0,1,9,10,0).
- MEM_WAIT_EN=0, mem_ready=0 constant, opcode=0x23 -> completes in 5 cycles, identical to the zero-wait case.
